key_scan_ctrl: RTL and testbench
================================

Name: key_scan_ctrl

Overview:
Keyboard scan sequencer for the POKEY keyboard path. It drives the 6-bit key-matrix scan counter and holds the compare register. It runs the two-bit debounce state machine that reads the KR1/KR2 return lines, latches KBCODE, and raises the keyboard IRQ request. It sits between the SKCTL bits, the external key matrix, and the IRQ/SKSTAT logic.

Parameters:
SHIFT_CODE, 6'h10, scan position at which KR2 reports SHIFT
CTRL_CODE, 6'h20, scan position at which KR2 reports CONTROL
BREAK_CODE, 6'h30, scan position at which KR2 reports BREAK (used only with the optional feature)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
scanStrobe  in  1  one-clk pulse per scan slot (line rate)
kbdEn  in  1  SKCTL bit1, keyboard scan enable
debEn  in  1  SKCTL bit0, debounce enable
iKR1  in  1  matrix return, 1 = key at kScan pressed
iKR2  in  1  modifier return, 1 = modifier at kScan pressed
kScan  out  6  current scan code to the matrix
kbCode  out  8  {ctrl, shift, code[5:0]}
keyIrq  out  1  one-clk pulse when a new key is accepted
keyDown  out  1  SKSTAT key-depressed, active-high
shiftDown  out  1  SKSTAT shift, active-high
breakIrq  out  1  one-clk break pulse (tied 0 without the optional feature)

Behaviour:
- Reset: kScan=0, compare=0, state=IDLE, kbCode=0, keyIrq=0, keyDown=0, shiftDown=0, breakIrq=0, ctrl/shift latches=0.
- All evaluation happens only on cycles with scanStrobe=1 and kbdEn=1.
  - iKR1/iKR2 refer to the kScan value present in that cycle.
  - kScan increments at the same edge, modulo 64 (6'h3F wraps to 0).
- kbdEn=0: kScan forced to 0, state forced to IDLE, keyDown and shiftDown cleared, kbCode retained, no pulses. This also applies if kbdEn drops mid-sequence.
- debComp = (kScan == compare) when debEn=1; debComp is forced to 1 when debEn=0.
- Modifiers: on a strobe with kScan==SHIFT_CODE, shift latch <= iKR2 and shiftDown <= iKR2. On a strobe with kScan==CTRL_CODE, ctrl latch <= iKR2.
- States use a 2-bit encoding:
  - IDLE (00): if iKR1, then compare <= kScan and go to CONFIRM.
  - CONFIRM (01): if !debComp, hold state. If debComp and iKR1, then kbCode <= {ctrl, shift, kScan}, pulse keyIrq, set keyDown, and go to HELD. If debComp and !iKR1, go to IDLE (bounce rejected).
  - HELD (11): if debComp and !iKR1, go to RELEASE. All other cases hold.
  - RELEASE (10): if debComp and !iKR1, clear keyDown and go to IDLE. If debComp and iKR1, go to HELD (bounce). Otherwise hold.
- debEn=0: every strobe matches, so a key is accepted on the strobe after first detection, even at a different code.
- Simultaneous events: a modifier update and a kbCode load on the same strobe use the pre-update modifier latches.
- Auto-repeat is not generated; software repeats.
- keyIrq and breakIrq are exactly 1 clk wide.
- Latency: a first press on strobe N gives keyIrq on the clk after strobe N+64 (debounce on) or N+1 (debounce off).

Optional Feature:
- Macro: KEY_SCAN_BREAK_EN.
- Defined: on a strobe with kScan==BREAK_CODE, an iKR2 rising edge (relative to the previous sample at that code) pulses breakIrq for one clk. A held BREAK does not repeat. The previous-sample flop resets to 0.
- Undefined: breakIrq tied to 0 and no break flop is generated.

Decomposition:
- Shared package pokey_key_pkg: state encodings (KS_IDLE=2'b00, KS_CONFIRM=2'b01, KS_RELEASE=2'b10, KS_HELD=2'b11), the KBCODE bit positions for ctrl and shift, and the 6-bit scan-width constant.
- Sub-module key_scan_cnt: the 6-bit counter with enable, clear and wrap, plus the compare register and the debComp equality output.

Test Plan:
- Reset, then kbdEn=1 with 70 strobes and no keys: kScan wraps 6'h3F->6'h00; no keyIrq; keyDown=0.
- debEn=1, iKR1 high at code 6'h12 on two consecutive scans with SHIFT held: exactly one keyIrq after the second scan; kbCode=8'h52; keyDown=1.
- debEn=1, iKR1 high at 6'h12 on the first scan only: no keyIrq; state returns to IDLE; kbCode unchanged.
- Key held, then released for two scans: keyDown clears on the second release scan. A single-scan release followed by a press keeps keyDown=1.
- debEn=0, press at 6'h05: keyIrq on the following strobe; kbCode=8'h05.
- KEY_SCAN_BREAK_EN defined, iKR2 high at BREAK_CODE for 3 scans: exactly one breakIrq. kbdEn dropped mid-HELD: keyDown=0 next clk and kScan=0.

Source files
------------

// File: rtl/pokey_key_pkg.sv
// Shared constants for the POKEY keyboard scan path: debounce state encodings,
// KBCODE bit positions and the fixed matrix scan positions of the modifiers.
package pokey_key_pkg;

  localparam int unsigned SCAN_W       = 6;
  localparam int unsigned KB_W         = 8;
  localparam int unsigned KB_CTRL_BIT  = 7;
  localparam int unsigned KB_SHIFT_BIT = 6;

  localparam logic [SCAN_W-1:0] SHIFT_CODE = 6'h10;
  localparam logic [SCAN_W-1:0] CTRL_CODE  = 6'h20;
  localparam logic [SCAN_W-1:0] BREAK_CODE = 6'h30;

  typedef enum logic [1:0] {
    KS_IDLE    = 2'b00,
    KS_CONFIRM = 2'b01,
    KS_RELEASE = 2'b10,
    KS_HELD    = 2'b11
  } ks_state_e;

endpackage

// File: rtl/key_scan_cnt.sv
// Key-matrix scan counter (wraps modulo 64) with the debounce compare register
// and its match output; a disabled debounce makes every slot match.
module key_scan_cnt
  import pokey_key_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_en,
  input  logic              i_clr,
  input  logic              i_ld,
  input  logic              i_deb_en,
  output logic [SCAN_W-1:0] o_scan,
  output logic              o_deb_comp_c
);

  logic [SCAN_W-1:0] r_scan;
  logic [SCAN_W-1:0] r_cmp;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_scan <= '0;
      r_cmp  <= '0;
    end else begin
      if (i_clr) begin
        r_scan <= '0;
      end else if (i_en) begin
        r_scan <= SCAN_W'(r_scan + 1'b1);
      end
      if (i_ld) begin
        r_cmp <= r_scan;
      end
    end
  end

  assign o_scan       = r_scan;
  assign o_deb_comp_c = i_deb_en ? (r_scan == r_cmp) : 1'b1;

endmodule

// File: rtl/key_scan_ctrl.sv
// POKEY keyboard scan sequencer: debounce FSM, modifier latches, KBCODE and IRQ.
// Define KEY_SCAN_BREAK_EN to build the BREAK-key edge detector on breakIrq.
module key_scan_ctrl
  import pokey_key_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              scanStrobe,
  input  logic              kbdEn,
  input  logic              debEn,
  input  logic              iKR1,
  input  logic              iKR2,
  output logic [SCAN_W-1:0] kScan,
  output logic [KB_W-1:0]   kbCode,
  output logic              keyIrq,
  output logic              keyDown,
  output logic              shiftDown,
  output logic              breakIrq
);

  ks_state_e         r_state;
  logic [KB_W-1:0]   r_kb_code;
  logic              r_key_irq;
  logic              r_key_down;
  logic              r_shift_down;
  logic              r_shift;
  logic              r_ctrl;
  logic              w_eval;
  logic              w_ld_cmp;
  logic              w_deb_comp;
  logic [SCAN_W-1:0] w_scan;

  assign w_eval   = scanStrobe & kbdEn;
  assign w_ld_cmp = w_eval & (r_state == KS_IDLE) & iKR1;

  key_scan_cnt u_cnt (
    .clk          (clk),
    .reset        (reset),
    .i_en         (w_eval),
    .i_clr        (~kbdEn),
    .i_ld         (w_ld_cmp),
    .i_deb_en     (debEn),
    .o_scan       (w_scan),
    .o_deb_comp_c (w_deb_comp)
  );

  // Modifier latches update in parallel with the FSM, so a same-strobe kbCode
  // load sees the previous modifier values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= KS_IDLE;
      r_kb_code    <= '0;
      r_key_irq    <= 1'b0;
      r_key_down   <= 1'b0;
      r_shift_down <= 1'b0;
      r_shift      <= 1'b0;
      r_ctrl       <= 1'b0;
    end else begin
      r_key_irq <= 1'b0;
      if (!kbdEn) begin
        r_state      <= KS_IDLE;
        r_key_down   <= 1'b0;
        r_shift_down <= 1'b0;
      end else if (scanStrobe) begin
        if (w_scan == SHIFT_CODE) begin
          r_shift      <= iKR2;
          r_shift_down <= iKR2;
        end
        if (w_scan == CTRL_CODE) begin
          r_ctrl <= iKR2;
        end
        case (r_state)
          KS_IDLE: begin
            if (iKR1) r_state <= KS_CONFIRM;
          end
          KS_CONFIRM: begin
            if (w_deb_comp) begin
              if (iKR1) begin
                r_kb_code[KB_CTRL_BIT]  <= r_ctrl;
                r_kb_code[KB_SHIFT_BIT] <= r_shift;
                r_kb_code[SCAN_W-1:0]   <= w_scan;
                r_key_irq               <= 1'b1;
                r_key_down              <= 1'b1;
                r_state                 <= KS_HELD;
              end else begin
                r_state <= KS_IDLE;
              end
            end
          end
          KS_HELD: begin
            if (w_deb_comp && !iKR1) r_state <= KS_RELEASE;
          end
          KS_RELEASE: begin
            if (w_deb_comp) begin
              if (iKR1) begin
                r_state <= KS_HELD;
              end else begin
                r_key_down <= 1'b0;
                r_state    <= KS_IDLE;
              end
            end
          end
          default: r_state <= KS_IDLE;
        endcase
      end
    end
  end

`ifdef KEY_SCAN_BREAK_EN
  logic r_break_prev;
  logic r_break_irq;

  // Rising edge of the BREAK return, sampled only at its own scan slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_break_prev <= 1'b0;
      r_break_irq  <= 1'b0;
    end else begin
      r_break_irq <= 1'b0;
      if (w_eval && (w_scan == BREAK_CODE)) begin
        r_break_prev <= iKR2;
        r_break_irq  <= iKR2 & ~r_break_prev;
      end
    end
  end

  assign breakIrq = r_break_irq;
`else
  assign breakIrq = 1'b0;
`endif

  assign kScan     = w_scan;
  assign kbCode    = r_kb_code;
  assign keyIrq    = r_key_irq;
  assign keyDown   = r_key_down;
  assign shiftDown = r_shift_down;

endmodule

// File: tb/tb_key_scan_ctrl.sv
// Self-checking bench for key_scan_ctrl: directed key-matrix scenarios with a
// kbCode scoreboard popped by a monitor on every keyIrq pulse.
module tb_key_scan_ctrl;

  logic       clk;
  logic       reset;
  logic       scanStrobe;
  logic       kbdEn;
  logic       debEn;
  logic       iKR1;
  logic       iKR2;
  logic [5:0] kScan;
  logic [7:0] kbCode;
  logic       keyIrq;
  logic       keyDown;
  logic       shiftDown;
  logic       breakIrq;

  key_scan_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .scanStrobe (scanStrobe),
    .kbdEn      (kbdEn),
    .debEn      (debEn),
    .iKR1       (iKR1),
    .iKR2       (iKR2),
    .kScan      (kScan),
    .kbCode     (kbCode),
    .keyIrq     (keyIrq),
    .keyDown    (keyDown),
    .shiftDown  (shiftDown),
    .breakIrq   (breakIrq)
  );

  int         checks = 0;
  int         errors = 0;
  int         break_cnt = 0;
  logic [7:0] exp_q[$];
  logic [63:0] keys = '0;
  logic [63:0] mods = '0;
  logic [5:0]  m_scan = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // One scan slot: strobe for one clk, then one idle clk.
  task automatic strobe();
    @(negedge clk);
    scanStrobe = 1'b1;
    iKR1 = keys[m_scan];
    iKR2 = mods[m_scan];
    @(negedge clk);
    scanStrobe = 1'b0;
    iKR1 = 1'b0;
    iKR2 = 1'b0;
    if (kbdEn) m_scan = 6'(m_scan + 1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) strobe();
  endtask

  // Scoreboard monitor: every keyIrq pulse must match the next expected kbCode.
  always @(negedge clk) begin
    if (!reset) begin
      if (keyIrq) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_keyIrq: kbCode %h with no expected press", kbCode);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (kbCode !== e) begin
            errors++;
            $display("FAIL kbCode_on_irq: got %h expected %h", kbCode, e);
          end
        end
      end
      if (breakIrq) break_cnt++;
    end
  end

  initial begin
    reset = 1'b1; scanStrobe = 1'b0; kbdEn = 1'b0; debEn = 1'b1;
    iKR1 = 1'b0; iKR2 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_kScan", {2'b0, kScan}, 8'h00);
    check("reset_kbCode", kbCode, 8'h00);
    check("reset_keyIrq", {7'b0, keyIrq}, 8'h00);
    check("reset_keyDown", {7'b0, keyDown}, 8'h00);
    check("reset_shiftDown", {7'b0, shiftDown}, 8'h00);
    check("reset_breakIrq", {7'b0, breakIrq}, 8'h00);

    // Idle scanning: wrap after 64 slots, then 6 more.
    kbdEn = 1'b1;
    run(64);
    check("wrap_kScan", {2'b0, kScan}, 8'h00);
    run(6);
    check("idle70_kScan", {2'b0, kScan}, 8'h06);
    check("idle70_keyDown", {7'b0, keyDown}, 8'h00);

    // Debounced press at 0x12 with SHIFT held.
    keys[6'h12] = 1'b1;
    mods[6'h10] = 1'b1;
    exp_q.push_back(8'h52);
    run(128);
    check("press_kbCode", kbCode, 8'h52);
    check("press_keyDown", {7'b0, keyDown}, 8'h01);
    check("press_shiftDown", {7'b0, shiftDown}, 8'h01);
    run(64);
    check("held_no_repeat_q", 8'(exp_q.size()), 8'h00);

    // One-scan release then press again: still held, no new IRQ.
    keys[6'h12] = 1'b0;
    run(64);
    check("release1_keyDown", {7'b0, keyDown}, 8'h01);
    keys[6'h12] = 1'b1;
    run(64);
    check("rebounce_keyDown", {7'b0, keyDown}, 8'h01);

    // Two-scan release clears keyDown on the second scan.
    keys[6'h12] = 1'b0;
    run(64);
    check("release_scan1_keyDown", {7'b0, keyDown}, 8'h01);
    run(64);
    check("release_scan2_keyDown", {7'b0, keyDown}, 8'h00);
    mods[6'h10] = 1'b0;
    run(64);
    check("shift_release", {7'b0, shiftDown}, 8'h00);

    // Bounce: seen on one scan only, rejected on the next.
    keys[6'h12] = 1'b1;
    run(13);
    keys[6'h12] = 1'b0;
    run(64);
    check("bounce_kbCode", kbCode, 8'h52);
    check("bounce_keyDown", {7'b0, keyDown}, 8'h00);

    // Debounce off: detect at 0x04, accept on the next strobe (0x05).
    debEn = 1'b0;
    keys[6'h04] = 1'b1;
    keys[6'h05] = 1'b1;
    exp_q.push_back(8'h05);
    while (m_scan != 6'h06) strobe();
    check("nodeb_keyDown", {7'b0, keyDown}, 8'h01);
    check("nodeb_kbCode", kbCode, 8'h05);
    keys[6'h04] = 1'b0;
    keys[6'h05] = 1'b0;
    run(2);
    check("nodeb_release", {7'b0, keyDown}, 8'h00);

    // CTRL-modified press, then kbdEn dropped while held.
    debEn = 1'b1;
    keys[6'h22] = 1'b1;
    mods[6'h20] = 1'b1;
    exp_q.push_back(8'hA2);
    run(128);
    check("ctrl_kbCode", kbCode, 8'hA2);
    check("ctrl_keyDown", {7'b0, keyDown}, 8'h01);
    @(negedge clk);
    kbdEn = 1'b0;
    @(negedge clk);
    m_scan = '0;
    check("kbd_off_keyDown", {7'b0, keyDown}, 8'h00);
    check("kbd_off_kScan", {2'b0, kScan}, 8'h00);
    check("kbd_off_kbCode", kbCode, 8'hA2);
    keys[6'h22] = 1'b0;
    mods[6'h20] = 1'b0;
    kbdEn = 1'b1;

    // BREAK held for three scans.
    mods[6'h30] = 1'b1;
    run(192);
    mods[6'h30] = 1'b0;
    run(64);
`ifdef KEY_SCAN_BREAK_EN
    check("break_pulses", 8'(break_cnt), 8'h01);
`else
    check("break_pulses", 8'(break_cnt), 8'h00);
`endif
    check("scoreboard_drained", 8'(exp_q.size()), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
